// File: rtl/ring_buffer_pkg.sv
// Default configuration shared by ring_buffer and the code that instantiates it.
package ring_buffer_pkg;

  localparam int unsigned DEFAULT_DATA_SIZE   = 32;
  localparam int unsigned DEFAULT_BUFFER_SIZE = 4;

endpackage : ring_buffer_pkg

// File: rtl/ring_buffer.sv
// FIFO ring buffer with valid/ack handshakes on both sides and a synchronous flush.
// Optional macro RING_BUFFER_FULL_BYPASS_EN: a full buffer accepts a word in the same cycle as a pop.
module ring_buffer
  import ring_buffer_pkg::*;
#(
  parameter int unsigned DATA_SIZE   = DEFAULT_DATA_SIZE,
  parameter int unsigned BUFFER_SIZE = DEFAULT_BUFFER_SIZE
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 buf_rst_i,
  input  logic                 rx_i,
  output logic                 rx_ack_o,
  input  logic [DATA_SIZE-1:0] data_i,
  output logic                 tx_o,
  input  logic                 tx_ack_i,
  output logic [DATA_SIZE-1:0] data_o
);

  localparam int unsigned PTR_W = $clog2(BUFFER_SIZE);
  localparam int unsigned CNT_W = $clog2(BUFFER_SIZE + 1);

  logic [PTR_W-1:0]     head;
  logic [PTR_W-1:0]     tail;
  logic [CNT_W-1:0]     count;
  logic [DATA_SIZE-1:0] storage [BUFFER_SIZE];

  logic empty;
  logic full;
  logic push;
  logic pop;

  // Explicit wrap so depths that are not a power of two work unchanged.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(BUFFER_SIZE - 1)) begin
      return '0;
    end
    return ptr + PTR_W'(1);
  endfunction

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(BUFFER_SIZE));

  assign tx_o = !empty;

`ifdef RING_BUFFER_FULL_BYPASS_EN
  // A pop in the same cycle frees the slot the incoming word will take.
  assign rx_ack_o = !full || tx_ack_i;
`else
  assign rx_ack_o = !full;
`endif

  assign push = rx_i && rx_ack_o;
  assign pop  = tx_o && tx_ack_i;

  assign data_o = storage[head];

  // NOTE: sequential state is assigned with <= so every register samples
  // pre-edge values; blocking assignments here would create ordering races.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (buf_rst_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= ptr_inc(tail);
      end
      if (pop) begin
        head <= ptr_inc(head);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is cleared on reset so data_o reads zero out of
  // reset; a flush only rewinds the pointers and leaves the contents intact.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(BUFFER_SIZE); i++) begin
        storage[i] <= '0;
      end
    end else if (push && !buf_rst_i) begin
      storage[tail] <= data_i;
    end
  end

endmodule : ring_buffer

// File: tb/tb_ring_buffer.sv
// Self-checking bench for ring_buffer: queue reference model, per-cycle compare, directed and random stimulus.
module tb_ring_buffer;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;

`ifdef RING_BUFFER_FULL_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          buf_rst_i;
  logic          rx_i;
  logic          rx_ack_o;
  logic [DW-1:0] data_i;
  logic          tx_o;
  logic          tx_ack_i;
  logic [DW-1:0] data_o;

  int vectors = 0;
  int errors  = 0;

  logic [DW-1:0] model_q [$];

  ring_buffer #(.DATA_SIZE(DW), .BUFFER_SIZE(DEPTH)) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .buf_rst_i (buf_rst_i),
    .rx_i      (rx_i),
    .rx_ack_o  (rx_ack_o),
    .data_i    (data_i),
    .tx_o      (tx_o),
    .tx_ack_i  (tx_ack_i),
    .data_o    (data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain FIFO queue updated from the handshake rules.
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      model_q.delete();
    end else if (buf_rst_i) begin
      model_q.delete();
    end else begin
      bit do_pop;
      bit do_push;
      do_pop  = (model_q.size() != 0) && tx_ack_i;
      do_push = rx_i && ((model_q.size() < DEPTH) || (BYPASS && tx_ack_i));
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back(data_i);
    end
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge clk_i) begin
    bit exp_ack;
    exp_ack = (model_q.size() < DEPTH) || (BYPASS && tx_ack_i);
    check("tx_o", DW'(tx_o), DW'(model_q.size() != 0));
    check("rx_ack_o", DW'(rx_ack_o), DW'(exp_ack));
    if (model_q.size() != 0) check("data_o", data_o, model_q[0]);
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input bit rx, input logic [DW-1:0] d, input bit ack, input bit flush);
    rx_i      = rx;
    data_i    = d;
    tx_ack_i  = ack;
    buf_rst_i = flush;
  endtask

  task automatic drain();
    drive(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 2 * DEPTH && tx_o; i++) tick();
    check("drain_empty", DW'(tx_o), DW'(0));
    drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    repeat (3) tick();
    rst_ni = 1'b1;

    // 1: reset values, first-push latency, pop order
    check("rst_tx", DW'(tx_o), DW'(0));
    check("rst_rx_ack", DW'(rx_ack_o), DW'(1));
    check("rst_data", data_o, DW'(0));
    drive(1'b1, 32'h1, 1'b0, 1'b0);
    tick();
    check("t1_tx_after_push", DW'(tx_o), DW'(1));
    check("t1_data_after_push", data_o, 32'h1);
    drive(1'b1, 32'h2, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b1, 1'b0);
    check("t1_pop0", data_o, 32'h1);
    tick();
    check("t1_pop1", data_o, 32'h2);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    check("t1_empty", DW'(tx_o), DW'(0));

    // 2: fill, back-pressure, release after one pop
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, DW'(32'hA + i), 1'b0, 1'b0);
      tick();
    end
    check("t2_full_ack", DW'(rx_ack_o), DW'(0));
    drive(1'b1, 32'hE, 1'b0, 1'b0);
    tick();
    check("t2_held_ack", DW'(rx_ack_o), DW'(0));
    check("t2_head", data_o, 32'hA);
    drive(1'b1, 32'hE, 1'b1, 1'b0);
    check("t2_pop_ack", DW'(rx_ack_o), DW'(BYPASS));
    tick();
    drive(1'b1, 32'hE, 1'b0, 1'b0);
    check("t2_after_pop_ack", DW'(rx_ack_o), DW'(!BYPASS));
    tick();
    drive(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("t2_drain", data_o, DW'(32'hB + i));
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    check("t2_empty", DW'(tx_o), DW'(0));

    // 3: steady push/pop pairs at occupancy 1, pointers wrap
    drive(1'b1, 32'h100, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, DW'(32'h101 + i), 1'b1, 1'b0);
      check("t3_data", data_o, DW'(32'h100 + i));
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    check("t3_last", data_o, 32'h10A);
    drain();

    // 4: flush overrides a concurrent push
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, DW'(32'h200 + i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 32'h2FF, 1'b0, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    check("t4_tx", DW'(tx_o), DW'(0));
    check("t4_rx_ack", DW'(rx_ack_o), DW'(1));
    tick();
    check("t4_still_empty", DW'(tx_o), DW'(0));

    // 5: asynchronous reset with two words stored
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, DW'(32'h300 + i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    rst_ni = 1'b0;
    #1;
    check("t5_tx_async", DW'(tx_o), DW'(0));
    check("t5_data_async", data_o, DW'(0));
    tick();
    rst_ni = 1'b1;
    tick();
    check("t5_empty_after", DW'(tx_o), DW'(0));

`ifdef RING_BUFFER_FULL_BYPASS_EN
    // 6: full-buffer bypass keeps occupancy and order
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, DW'(32'h400 + i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 32'h404, 1'b1, 1'b0);
    check("t6_bypass_ack", DW'(rx_ack_o), DW'(1));
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    check("t6_still_full", DW'(rx_ack_o), DW'(0));
    drive(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("t6_order", data_o, DW'(32'h401 + i));
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
`endif

    // Random traffic with occasional flushes, checked by the compare process.
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 99) < 60), DW'($urandom()),
            ($urandom_range(0, 99) < 45), ($urandom_range(0, 63) == 0));
      tick();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule : tb_ring_buffer
